// File: rtl/state_store_pkg.sv
// ----------------------------------------------------------------------------
// state_store_pkg
//   Shared sizes and types for the state store slice.
//   NUM_WORDS / DATA_WIDTH / IDX_WIDTH size the state array, FIFO_DEPTH sizes
//   the host write queue, CNT_WIDTH sizes its occupancy count.
//   wr_req_t is one queued host write {idx, data}.
//   clr_state_e is the clear-sweep FSM state (used only when
//   STATE_STORE_CLEAR_EN is defined).
// ----------------------------------------------------------------------------
package state_store_pkg;

    localparam int NUM_WORDS  = 1024;
    localparam int DATA_WIDTH = 32;
    localparam int IDX_WIDTH  = $clog2(NUM_WORDS);
    localparam int FIFO_DEPTH = 4;
    localparam int CNT_WIDTH  = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [IDX_WIDTH-1:0]  idx;
        logic [DATA_WIDTH-1:0] data;
    } wr_req_t;

    typedef enum logic {
        CLR_IDLE  = 1'b0,
        CLR_SWEEP = 1'b1
    } clr_state_e;

endpackage

// File: rtl/state_wr_fifo.sv
// ----------------------------------------------------------------------------
// state_wr_fifo
//   Synchronous FIFO of wr_req_t used to order host writes.
//   Ports:
//     clk, rst      clock, synchronous active-high reset (discards contents)
//     push, din     enqueue request; ignored when full unless pop is also set
//     pop, dout     dequeue; dout is the current head (valid when !empty)
//     full, empty   occupancy flags
//     count         number of queued entries (0..DEPTH)
//   DEPTH must be a power of two so the pointers wrap for free.
// ----------------------------------------------------------------------------
module state_wr_fifo
    import state_store_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  wr_req_t          din,
    input  logic             pop,
    output wr_req_t          dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    wr_req_t          mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    always_comb begin
        // A push into a full queue is only taken when a pop frees the slot
        // in the same cycle; the head is read before the slot is rewritten.
        do_push  = push & (~full | pop);
        do_pop   = pop & ~empty;
        wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        if (do_push & ~do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_pop & ~do_push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read behind a valid count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/state_store.sv
// ----------------------------------------------------------------------------
// state_store
//   Owns the NUM_WORDS x DATA_WIDTH state array, exposed flat on state_rd.
//   One write commits per cycle, chosen from (highest first):
//     1. queue head        (write_bypass=1, queue non-empty)
//     2. direct host write (write_bypass=1, queue empty, state_wr_valid!=0)
//     3. engine write      (upd_valid & upd_ready)
//     4. queue head        (write_bypass=0, no engine handshake)
//   Host writes that do not commit directly are queued, so host ordering is
//   preserved across write_bypass changes. Index 0 never comes from the host.
//   Ports:
//     s_aclk, s_areset        clock, synchronous active-high reset
//     state_wr/state_wr_valid host write data / index (index 0 = no write)
//     write_bypass            allow direct host commits when queue empty
//     upd_valid/ready/idx/data engine write handshake
//     state_rd                registered array, word i at [i*32 +: 32]
//     host_pending            queued host writes
//     host_overflow           sticky: a host write was dropped (queue full)
//     clear_req, clear_busy   only with STATE_STORE_CLEAR_EN: a clear_req
//                             while idle sweeps 0 into every word, one word
//                             per cycle, with clear_busy high for the sweep
// ----------------------------------------------------------------------------
module state_store
    import state_store_pkg::*;
(
    input  logic                            s_aclk,
    input  logic                            s_areset,
    input  logic [DATA_WIDTH-1:0]           state_wr,
    input  logic [IDX_WIDTH-1:0]            state_wr_valid,
    input  logic                            write_bypass,
    input  logic                            upd_valid,
    output logic                            upd_ready,
    input  logic [IDX_WIDTH-1:0]            upd_idx,
    input  logic [DATA_WIDTH-1:0]           upd_data,
`ifdef STATE_STORE_CLEAR_EN
    input  logic                            clear_req,
    output logic                            clear_busy,
`endif
    output logic [NUM_WORDS*DATA_WIDTH-1:0] state_rd,
    output logic [CNT_WIDTH-1:0]            host_pending,
    output logic                            host_overflow
);

    logic [NUM_WORDS-1:0][DATA_WIDTH-1:0] mem_q;

    logic                  host_v;
    logic                  direct;
    logic                  commit_en;
    logic [IDX_WIDTH-1:0]  commit_idx;
    logic [DATA_WIDTH-1:0] commit_data;

    logic                  q_push, q_pop, q_full, q_empty;
    wr_req_t               q_din, q_head;
    logic [CNT_WIDTH-1:0]  q_count;

    logic                  overflow_q, overflow_d;

    logic                  clr_busy;
    logic [IDX_WIDTH-1:0]  clr_idx;

    // ------------------------------------------------------------------
    // Optional clear sweep
    // ------------------------------------------------------------------
`ifdef STATE_STORE_CLEAR_EN
    clr_state_e            clr_state_q;
    logic [IDX_WIDTH-1:0]  clr_idx_q;
    logic                  clear_busy_q;

    always_ff @(posedge s_aclk) begin
        if (s_areset) begin
            clr_state_q  <= CLR_IDLE;
            clr_idx_q    <= '0;
            clear_busy_q <= 1'b0;
        end else begin
            case (clr_state_q)
                CLR_IDLE: begin
                    if (clear_req) begin
                        clr_state_q  <= CLR_SWEEP;
                        clr_idx_q    <= '0;
                        clear_busy_q <= 1'b1;
                    end
                end
                CLR_SWEEP: begin
                    // clear_req is ignored here; the sweep always finishes.
                    clr_idx_q <= clr_idx_q + IDX_WIDTH'(1);
                    if (clr_idx_q == IDX_WIDTH'(NUM_WORDS - 1)) begin
                        clr_state_q  <= CLR_IDLE;
                        clear_busy_q <= 1'b0;
                    end
                end
                default: begin
                    clr_state_q  <= CLR_IDLE;
                    clear_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign clr_busy   = clear_busy_q;
    assign clr_idx    = clr_idx_q;
    assign clear_busy = clear_busy_q;
`else
    assign clr_busy = 1'b0;
    assign clr_idx  = '0;
`endif

    // ------------------------------------------------------------------
    // Host write queue
    // ------------------------------------------------------------------
    assign q_din = '{idx: state_wr_valid, data: state_wr};

    state_wr_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (s_aclk),
        .rst   (s_areset),
        .push  (q_push),
        .din   (q_din),
        .pop   (q_pop),
        .dout  (q_head),
        .full  (q_full),
        .empty (q_empty),
        .count (q_count)
    );

    // ------------------------------------------------------------------
    // Commit arbitration
    // ------------------------------------------------------------------
    always_comb begin
        host_v = |state_wr_valid;
        // Depends only on inputs and queue state, never on upd_valid, so
        // the engine side sees no combinational loop.
        upd_ready = ~s_areset
                  & ~(write_bypass & (~q_empty | host_v))
                  & ~clr_busy;

        commit_en   = 1'b0;
        commit_idx  = '0;
        commit_data = '0;
        q_pop       = 1'b0;
        direct      = 1'b0;

        if (clr_busy) begin
            // Sweep owns the port; queue holds, engine is stalled.
            commit_en   = 1'b1;
            commit_idx  = clr_idx;
            commit_data = '0;
        end else if (write_bypass & ~q_empty) begin
            commit_en   = 1'b1;
            commit_idx  = q_head.idx;
            commit_data = q_head.data;
            q_pop       = 1'b1;
        end else if (write_bypass & host_v) begin
            commit_en   = 1'b1;
            commit_idx  = state_wr_valid;
            commit_data = state_wr;
            direct      = 1'b1;
        end else if (upd_valid & upd_ready) begin
            commit_en   = 1'b1;
            commit_idx  = upd_idx;
            commit_data = upd_data;
        end else if (~write_bypass & ~q_empty) begin
            commit_en   = 1'b1;
            commit_idx  = q_head.idx;
            commit_data = q_head.data;
            q_pop       = 1'b1;
        end

        // Every host write that is not committed directly joins the queue,
        // including bypass mode with older writes still queued.
        q_push     = host_v & ~direct;
        overflow_d = overflow_q | (q_push & q_full & ~q_pop);
    end

    // ------------------------------------------------------------------
    // State array and sticky overflow
    // ------------------------------------------------------------------
    always_ff @(posedge s_aclk) begin
        if (s_areset) begin
            mem_q <= '0;
        end else if (commit_en) begin
            mem_q[commit_idx] <= commit_data;
        end
    end

    always_ff @(posedge s_aclk) begin
        if (s_areset) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign state_rd      = mem_q;
    assign host_pending  = q_count;
    assign host_overflow = overflow_q;

endmodule

// File: tb/tb_state_store.sv
module tb_state_store;
    import state_store_pkg::*;

    localparam int W = NUM_WORDS * DATA_WIDTH;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [31:0]          wr_data;
    logic [9:0]           wr_idx;
    logic                 bp;
    logic                 uv;
    logic                 ready;
    logic [9:0]           uidx;
    logic [31:0]          udata;
    logic [W-1:0]         state_rd;
    logic [CNT_WIDTH-1:0] pend;
    logic                 ovf;
    logic                 clr_req;
    logic                 clr_busy;

    always #5 clk = ~clk;

    state_store dut (
        .s_aclk         (clk),
        .s_areset       (rst),
        .state_wr       (wr_data),
        .state_wr_valid (wr_idx),
        .write_bypass   (bp),
        .upd_valid      (uv),
        .upd_ready      (ready),
        .upd_idx        (uidx),
        .upd_data       (udata),
`ifdef STATE_STORE_CLEAR_EN
        .clear_req      (clr_req),
        .clear_busy     (clr_busy),
`endif
        .state_rd       (state_rd),
        .host_pending   (pend),
        .host_overflow  (ovf)
    );

`ifndef STATE_STORE_CLEAR_EN
    assign clr_busy = 1'b0;
`endif

    // ---------------- reference model ----------------
    typedef struct {
        logic [9:0]  idx;
        logic [31:0] data;
    } ent_t;

    logic [31:0] m_mem [NUM_WORDS];
    ent_t        mq [$];
    bit          m_ovf;
    bit          m_fire;
    int          m_clr_k = -1;   // sweep position, -1 when not sweeping

    int checks = 0;
    int errors = 0;

    function automatic bit m_ready();
        if (rst) return 1'b0;
        if (m_clr_k >= 0) return 1'b0;
        return !(bp && (mq.size() != 0 || wr_idx != 0));
    endfunction

    task automatic model_step();
        bit   rdy;
        bit   direct;
        ent_t e;
        rdy    = m_ready();
        m_fire = 1'b0;
        direct = 1'b0;
        if (rst) begin
            foreach (m_mem[i]) m_mem[i] = '0;
            mq.delete();
            m_ovf   = 1'b0;
            m_clr_k = -1;
            return;
        end
        if (m_clr_k >= 0) begin
            m_mem[m_clr_k] = '0;
        end else if (bp && mq.size() != 0) begin
            e = mq.pop_front();
            m_mem[e.idx] = e.data;
        end else if (bp && wr_idx != 0) begin
            m_mem[wr_idx] = wr_data;
            direct = 1'b1;
        end else if (uv && rdy) begin
            m_mem[uidx] = udata;
            m_fire = 1'b1;
        end else if (!bp && mq.size() != 0) begin
            e = mq.pop_front();
            m_mem[e.idx] = e.data;
        end
        if (wr_idx != 0 && !direct) begin
            if (mq.size() < FIFO_DEPTH) mq.push_back('{wr_idx, wr_data});
            else m_ovf = 1'b1;
        end
        if (m_clr_k >= 0) begin
            m_clr_k++;
            if (m_clr_k == NUM_WORDS) m_clr_k = -1;
        end else if (clr_req) begin
            m_clr_k = 0;
        end
    endtask

    function automatic logic [W-1:0] exp_flat();
        logic [W-1:0] f;
        for (int i = 0; i < NUM_WORDS; i++) f[i*32 +: 32] = m_mem[i];
        return f;
    endfunction

    function automatic int first_diff();
        for (int i = 0; i < NUM_WORDS; i++)
            if (state_rd[i*32 +: 32] !== m_mem[i]) return i;
        return 0;
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_idx  = '0;
        wr_data = '0;
        uv      = 1'b0;
        uidx    = '0;
        udata   = '0;
        bp      = 1'b0;
        clr_req = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        uv  = 1'b1;
        #1;
        checks++;
        if (ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready got %0b exp 0", ready);
        end
        tick();
        tick();
        rst = 1'b0;
        uv  = 1'b0;
        checks++;
        if (state_rd !== '0) begin
            errors++; $display("FAIL reset_array word %0d got %h exp 0", first_diff(), state_rd[first_diff()*32 +: 32]);
        end
        checks++;
        if (pend !== '0 || ovf !== 1'b0 || clr_busy !== 1'b0) begin
            errors++; $display("FAIL reset_flags got pend=%0d ovf=%0b busy=%0b exp 0/0/0", pend, ovf, clr_busy);
        end
        #1;
        checks++;
        if (ready !== 1'b1) begin
            errors++; $display("FAIL ready_idle got %0b exp 1", ready);
        end
    endtask

    task automatic test_bypass_direct();
        do_reset();
        bp = 1'b1; wr_idx = 10'd5; wr_data = 32'hDEADBEEF;
        uv = 1'b1; uidx = 10'd7; udata = 32'h1;
        #1;
        checks++;
        if (ready !== 1'b0 || pend !== '0) begin
            errors++; $display("FAIL direct_ready got ready=%0b pend=%0d exp 0/0", ready, pend);
        end
        tick();
        idle_inputs();
        checks++;
        if (state_rd[5*32 +: 32] !== 32'hDEADBEEF || state_rd[7*32 +: 32] !== 32'h0 || pend !== '0) begin
            errors++; $display("FAIL direct_commit got w5=%h w7=%h pend=%0d exp DEADBEEF/0/0",
                               state_rd[5*32 +: 32], state_rd[7*32 +: 32], pend);
        end
    endtask

    task automatic test_queue_fill(input bit with_overflow);
        int exp_p;
        do_reset();
        bp = 1'b0; uv = 1'b1; uidx = 10'd100;
        for (int i = 0; i < 6; i++) begin
            udata = 32'h5000 + i;
            if (i < 4) begin
                wr_idx = 10'(i + 1); wr_data = 32'h1000 + i;
            end else if (i == 4 && with_overflow) begin
                wr_idx = 10'd9; wr_data = 32'h9999;
            end else begin
                wr_idx = '0;
            end
            #1;
            checks++;
            if (ready !== 1'b1) begin
                errors++; $display("FAIL fill_ready cyc %0d got %0b exp 1", i, ready);
            end
            tick();
            exp_p = (i + 1 < 4) ? i + 1 : 4;
            checks++;
            if (pend !== CNT_WIDTH'(exp_p) || ovf !== (with_overflow && i >= 4)) begin
                errors++; $display("FAIL fill_pending cyc %0d got pend=%0d ovf=%0b exp %0d/%0b",
                                   i, pend, ovf, exp_p, with_overflow && i >= 4);
            end
        end
        idle_inputs();
        for (int k = 1; k <= 4; k++) begin
            tick();
            checks++;
            if (state_rd[k*32 +: 32] !== 32'h1000 + k - 1 ||
                (k < 4 && state_rd[(k+1)*32 +: 32] !== 32'h0)) begin
                errors++; $display("FAIL drain_order word %0d got %h exp %h", k,
                                   state_rd[k*32 +: 32], 32'h1000 + k - 1);
            end
        end
        tick();
        checks++;
        if (pend !== '0 || state_rd[9*32 +: 32] !== 32'h0 || ovf !== with_overflow) begin
            errors++; $display("FAIL drain_end got pend=%0d w9=%h ovf=%0b exp 0/0/%0b",
                               pend, state_rd[9*32 +: 32], ovf, with_overflow);
        end
        checks++;
        if (state_rd !== exp_flat()) begin
            errors++; $display("FAIL fill_model word %0d got %h exp %h", first_diff(),
                               state_rd[first_diff()*32 +: 32], m_mem[first_diff()]);
        end
    endtask

    task automatic test_order();
        do_reset();
        bp = 1'b0; uv = 1'b1; uidx = 10'd50; udata = 32'h50;
        wr_idx = 10'd3; wr_data = 32'hA;
        tick();
        wr_data = 32'hB;
        tick();
        checks++;
        if (pend !== CNT_WIDTH'(2) || state_rd[3*32 +: 32] !== 32'h0) begin
            errors++; $display("FAIL order_queued got pend=%0d w3=%h exp 2/0", pend, state_rd[3*32 +: 32]);
        end
        bp = 1'b1; uv = 1'b0; wr_data = 32'hC;
        #1;
        checks++;
        if (ready !== 1'b0) begin
            errors++; $display("FAIL order_ready got %0b exp 0", ready);
        end
        tick();
        wr_idx = '0;
        checks++;
        if (state_rd[3*32 +: 32] !== 32'hA || pend !== CNT_WIDTH'(2)) begin
            errors++; $display("FAIL order_a got w3=%h pend=%0d exp A/2", state_rd[3*32 +: 32], pend);
        end
        tick();
        checks++;
        if (state_rd[3*32 +: 32] !== 32'hB) begin
            errors++; $display("FAIL order_b got w3=%h exp B", state_rd[3*32 +: 32]);
        end
        tick();
        tick();
        checks++;
        if (state_rd[3*32 +: 32] !== 32'hC || pend !== '0) begin
            errors++; $display("FAIL order_c got w3=%h pend=%0d exp C/0", state_rd[3*32 +: 32], pend);
        end
    endtask

    task automatic test_word0();
        do_reset();
        bp = 1'b0; uv = 1'b1; uidx = 10'd0; udata = 32'h7;
        tick();
        uv = 1'b0; wr_idx = 10'd0; wr_data = 32'hFF;
        tick();
        bp = 1'b1;
        tick();
        checks++;
        if (state_rd[31:0] !== 32'h7 || pend !== '0) begin
            errors++; $display("FAIL word0 got w0=%h pend=%0d exp 7/0", state_rd[31:0], pend);
        end
        idle_inputs();
    endtask

    task automatic test_reset_midop();
        do_reset();
        bp = 1'b0; uv = 1'b1; uidx = 10'd40; udata = 32'h44;
        for (int i = 0; i < 3; i++) begin
            wr_idx = 10'(20 + i); wr_data = 32'h2000 + i;
            tick();
        end
        rst = 1'b1; wr_idx = 10'd30; wr_data = 32'h3030;
        tick();
        rst = 1'b0;
        idle_inputs();
        checks++;
        if (pend !== '0 || state_rd !== '0) begin
            errors++; $display("FAIL midop_reset got pend=%0d word %0d=%h exp 0", pend, first_diff(),
                               state_rd[first_diff()*32 +: 32]);
        end
        tick(); tick(); tick();
        checks++;
        if (state_rd !== '0) begin
            errors++; $display("FAIL midop_inflight word %0d got %h exp 0", first_diff(),
                               state_rd[first_diff()*32 +: 32]);
        end
    endtask

    task automatic test_random();
        do_reset();
        m_fire = 1'b1;
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 15) == 0) bp = ~bp;
            wr_data = $urandom;
            wr_idx  = $urandom_range(0, 1) ? 10'($urandom_range(0, 15)) : 10'd0;
            if (!uv || m_fire) begin
                uv    = ($urandom_range(0, 9) < 7);
                uidx  = 10'($urandom_range(0, 15));
                udata = $urandom;
            end
            #1;
            checks++;
            if (ready !== m_ready() || pend !== CNT_WIDTH'(mq.size())) begin
                errors++; $display("FAIL rand_ready cyc %0d got ready=%0b pend=%0d exp %0b/%0d",
                                   c, ready, pend, m_ready(), mq.size());
            end
            tick();
            checks++;
            if (ovf !== m_ovf || state_rd !== exp_flat()) begin
                errors++; $display("FAIL rand_state cyc %0d ovf=%0b exp %0b word %0d got %h exp %h",
                                   c, ovf, m_ovf, first_diff(), state_rd[first_diff()*32 +: 32],
                                   m_mem[first_diff()]);
            end
        end
        rst = 1'b0;
        idle_inputs();
    endtask

`ifdef STATE_STORE_CLEAR_EN
    task automatic test_clear();
        int busy_n;
        do_reset();
        uv = 1'b1;
        for (int i = 0; i < 8; i++) begin
            uidx = 10'(i); udata = 32'(i + 1);
            tick();
        end
        uv = 1'b0;
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        busy_n = 0;
        for (int c = 0; c < 1100; c++) begin
            checks++;
            if (clr_busy !== (m_clr_k >= 0)) begin
                errors++; $display("FAIL clear_busy cyc %0d got %0b exp %0b", c, clr_busy, m_clr_k >= 0);
            end
            if (!clr_busy) break;
            busy_n++;
            wr_idx = '0;
            clr_req = 1'b0;
            if (busy_n == 10) begin
                bp = 1'b1; wr_idx = 10'd12; wr_data = 32'hC0FFEE;
            end
            if (busy_n == 20) clr_req = 1'b1;
            if (busy_n == 30) begin
                uv = 1'b1; uidx = 10'd13; udata = 32'h5;
                #1;
                checks++;
                if (ready !== 1'b0 || pend !== CNT_WIDTH'(1)) begin
                    errors++; $display("FAIL clear_hold got ready=%0b pend=%0d exp 0/1", ready, pend);
                end
            end
            tick();
        end
        checks++;
        if (busy_n != NUM_WORDS) begin
            errors++; $display("FAIL clear_len got %0d exp %0d", busy_n, NUM_WORDS);
        end
        checks++;
        if (state_rd !== '0) begin
            errors++; $display("FAIL clear_zero word %0d got %h exp 0", first_diff(),
                               state_rd[first_diff()*32 +: 32]);
        end
        tick();
        tick();
        checks++;
        if (state_rd[12*32 +: 32] !== 32'hC0FFEE || state_rd[13*32 +: 32] !== 32'h5 ||
            state_rd !== exp_flat()) begin
            errors++; $display("FAIL clear_after got w12=%h w13=%h exp C0FFEE/5",
                               state_rd[12*32 +: 32], state_rd[13*32 +: 32]);
        end
        idle_inputs();
    endtask
`endif

    initial begin
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_bypass_direct();
        test_queue_fill(1'b0);
        test_queue_fill(1'b1);
        test_order();
        test_word0();
        test_reset_midop();
        test_random();
`ifdef STATE_STORE_CLEAR_EN
        test_clear();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
